div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle 32-bit integer divider for the DIV/DIVU instructions. Sits downstream of the instruction controller, beside the HI/LO registers.
- Accepts operands on a one-cycle start pulse and holds a busy stall for the pipeline while it runs.
- Returns the quotient (written to LO) and the remainder (written to HI) together with a one-cycle done pulse.
- Uses a restoring shift-subtract algorithm on operand magnitudes, then applies a sign fix-up.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend  in  WIDTH  rs operand; captured with start.
- divisor  in  WIDTH  rt operand; captured with start.
- busy  out  1  high while an operation is in flight; the pipeline stalls on it.
- done  out  1  one-cycle pulse: results valid; controller asserts HI_w/LO_w in this cycle.
- quotient  out  WIDTH  result to LO; held until the next accepted start.
- remainder  out  WIDTH  result to HI; held until the next accepted start.
- div_zero  out  1  set with done when divisor was 0; cleared on the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0; internal shift registers cleared.
- Reset asserted mid-operation aborts immediately; no done pulse is produced for the aborted request.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge:
  - Capture operands and is_signed.
  - Form magnitudes: |x| for signed negatives, raw value otherwise.
  - Record sign_q = dividend[31]^divisor[31] and sign_r = dividend[31]; both are 0 when unsigned.
  - Clear the counter and go to CALC. busy=1 from the next cycle.
- IDLE, divisor==0 at start: go directly to FIX and set the zero flag.
- CALC: one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem - |divisor| at WIDTH+1 bits.
  - Non-negative result: rem=diff, quo[0]=1. Negative: rem unchanged, quo[0]=0.
  - After WIDTH iterations (counter==WIDTH-1), go to FIX.
- FIX: one cycle.
  - quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
  - Divide by zero: quotient = all-ones, remainder = dividend (raw), div_zero=1.
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency, with start high in cycle 0:
  - busy=1 in cycles 1..WIDTH+1.
  - done=1 in cycle WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero path: done in cycle 2.
- start while busy or in DONE is ignored; no queuing. The controller holds its stall until done.
- start in the same cycle that DONE returns to IDLE is not possible (DONE lasts one cycle); start in the following IDLE cycle is accepted.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out of the magnitude path; no special case.
- Remainder sign always follows the dividend. Quotient truncates toward zero.
- Outputs hold their last values in IDLE.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of magnitudes), skip CALC and go straight to FIX.
  - quo=0, rem=|dividend|; the sign fix then yields remainder = dividend.
  - done arrives in cycle 2.
- Not defined: every nonzero-divisor operation takes the full WIDTH+2 cycle latency.

Test Plan:
- DIVU 100/7 -> done in cycle 34, quotient=14, remainder=2, div_zero=0; busy high cycles 1..33.
- DIV 0xFFFFFF9C (-100) / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU of the same operands -> quotient=0, remainder=0x80000000 (the early-exit path when DIV_EARLY_EXIT_EN is defined).
- DIVU 5/0 -> done in cycle 2, quotient=0xFFFFFFFF, remainder=5, div_zero=1; the next valid start clears div_zero.
- Start 1000/3; assert rst in cycle 10 for 1 cycle -> all outputs 0 and no done; start 9/4 in cycle 12 -> quotient=2, remainder=1 at cycle 46.
- Second start pulses in cycles 5 and 20 during busy -> ignored; results reflect only the first operands. With DIV_EARLY_EXIT_EN, DIVU 3/10 -> done in cycle 2, quotient=0, remainder=3.

Source files
------------

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Optional macro DIV_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|.
module div_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] raw_a;
   logic             sign_q;
   logic             sign_r;
   logic             zero;

   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             skip;

   assign neg_a = is_signed & dividend[WIDTH-1];
   assign neg_b = is_signed & divisor[WIDTH-1];
   assign mag_a = neg_a ? -dividend : dividend;
   assign mag_b = neg_b ? -divisor : divisor;

   // Shifted partial remainder needs WIDTH+1 bits; the extra top bit of diff is the borrow.
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, dvs};

`ifdef DIV_EARLY_EXIT_EN
   assign skip = (divisor != '0) && (mag_a < mag_b);
`else
   assign skip = 1'b0;
`endif

   assign busy = (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         raw_a     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         zero      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  raw_a    <= dividend;
                  dvs      <= mag_b;
                  sign_q   <= neg_a ^ neg_b;
                  sign_r   <= neg_a;
                  cnt      <= '0;
                  div_zero <= 1'b0;
                  zero     <= (divisor == '0);
                  if (divisor == '0) begin
                     quo   <= '0;
                     rem   <= '0;
                     state <= S_FIX;
                  end else if (skip) begin
                     quo   <= '0;
                     rem   <= mag_a;
                     state <= S_FIX;
                  end else begin
                     quo   <= mag_a;
                     rem   <= '0;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!diff[WIDTH+1]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               if (zero) begin
                  quotient  <= '1;
                  remainder <= raw_a;
                  div_zero  <= 1'b1;
               end else begin
                  quotient  <= sign_q ? -quo : quo;
                  remainder <= sign_r ? -rem : rem;
               end
               state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus random DIV/DIVU
// operations compared against arithmetic reference results and expected latency.
module tb_div_iter_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   div_iter_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output int lat);
      longint sa, sb, ma, mb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      if (b == 32'd0) begin
         q   = 32'hFFFF_FFFF;
         r   = a;
         lat = 2;
      end else begin
         q   = 32'(sa / sb);
         r   = 32'(sa % sb);
         lat = 34;
`ifdef DIV_EARLY_EXIT_EN
         if (ma < mb) lat = 2;
`endif
      end
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Caller is positioned #1 after a posedge with the DUT idle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit extra);
      logic [31:0] eq, er;
      int lat;
      model(a, b, s, eq, er, lat);
      start = 1'b1; dividend = a; divisor = b; is_signed = s;
      next_cycle();
      start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
      for (int cyc = 1; cyc <= lat; cyc++) begin
         if (cyc == 1) check("div_zero_clear", {31'd0, div_zero}, 32'd0);
         check("busy", {31'd0, busy}, {31'd0, cyc < lat});
         check("done", {31'd0, done}, {31'd0, cyc == lat});
         if (cyc == lat) begin
            check("quotient", quotient, eq);
            check("remainder", remainder, er);
            check("div_zero", {31'd0, div_zero}, {31'd0, b == 32'd0});
         end
         start = extra && (cyc == 5 || cyc == 20);
         if (start) begin
            dividend = $urandom; divisor = $urandom_range(1, 50); is_signed = $urandom_range(0, 1);
         end
         next_cycle();
      end
      start = 1'b0;
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("q_hold", quotient, eq);
      check("r_hold", remainder, er);
   endtask

   initial begin
      logic [31:0] a, b;
      logic s;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      rst = 1'b0;
      next_cycle();

      run_op(32'd100, 32'd7, 1'b0, 1'b0);
      run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 1'b0);
      run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
      run_op(32'd3, 32'd10, 1'b0, 1'b0);
      run_op(32'd1234567, 32'd89, 1'b0, 1'b1);

      // Reset mid-operation: start 1000/3, reset in cycle 10, restart in cycle 12.
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
      next_cycle();
      start = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) next_cycle();
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_q", quotient, 32'd0);
      check("abort_r", remainder, 32'd0);
      next_cycle();
      rst = 1'b0;
      check("abort_nodone11", {31'd0, done}, 32'd0);
      next_cycle();
      check("abort_nodone12", {31'd0, done}, 32'd0);
      run_op(32'd9, 32'd4, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         s = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: b = -$urandom_range(1, 20);
            3: b = $urandom;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if (i % 5 == 0) a = $urandom_range(0, 15);
         run_op(a, b, s, (i % 3 == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
